// File: rtl/tick_pkg.sv
// Shared constants, encodings and FSM state type for the tick decoder.
// Imported by the decoder top.
package tick_pkg;

    localparam logic [7:0] TYPE_ADD    = 8'h41;
    localparam logic [7:0] TYPE_DEL    = 8'h58;
    localparam logic [7:0] SIDE_BID_CH = 8'h42;
    localparam logic [7:0] SIDE_ASK_CH = 8'h53;
    localparam int         MSG_LEN     = 10;

    localparam logic TICK_ADD = 1'b0;
    localparam logic TICK_DEL = 1'b1;
    localparam logic SIDE_BID = 1'b1;
    localparam logic SIDE_ASK = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SIDE    = 2'd1,
        ST_BODY    = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

    function automatic logic type_legal(input logic [7:0] b);
        return (b == TYPE_ADD) || (b == TYPE_DEL);
    endfunction

    function automatic logic side_legal(input logic [7:0] b);
        return (b == SIDE_BID_CH) || (b == SIDE_ASK_CH);
    endfunction

endpackage

// File: rtl/tick_decoder_if.sv
// Byte-stream input and tick output bundle of the tick decoder.
// master = stream source / tick consumer, slave = decoder.
interface tick_decoder_if #(
    parameter int QTY_W = 32,
    parameter int PX_W  = 32
) ();
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic             tick_valid;
    logic             tick_type;
    logic             tick_side;
    logic [QTY_W-1:0] tick_qty;
    logic [PX_W-1:0]  tick_price;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, tick_valid, tick_type, tick_side, tick_qty, tick_price
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, tick_valid, tick_type, tick_side, tick_qty, tick_price
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count up on inc, holding once the all-ones value is reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end
    end

    assign count = count_r;

endmodule

// File: rtl/tick_decoder.sv
// Decodes 10-byte order frames into a one-cycle tick strobe for book2,
// dropping malformed frames and counting emitted and rejected frames.
module tick_decoder
    import tick_pkg::*;
#(
    parameter int QTY_W = 32,
    parameter int PX_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    tick_decoder_if.slave    bus,
    output logic [CNT_W-1:0] msg_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_e      state_r, state_s;
    logic [3:0]  byte_idx_r, byte_idx_s;
    logic [31:0] qty_r, qty_s;
    // Only b6..b8 are held; b9 completes the price combinationally.
    logic [23:0] price_r, price_s;
    logic        type_r, type_s;
    logic        side_r, side_s;
    logic        emit_s, err_s;
    logic [31:0] price_full_s;

    logic             tick_valid_r;
    logic             tick_type_r;
    logic             tick_side_r;
    logic [QTY_W-1:0] tick_qty_r;
    logic [PX_W-1:0]  tick_price_r;

    assign price_full_s = {price_r, bus.in_data};

    // Next-state, field capture and error/emit decisions for each accepted byte.
    always_comb begin
        state_s    = state_r;
        byte_idx_s = byte_idx_r;
        qty_s      = qty_r;
        price_s    = price_r;
        type_s     = type_r;
        side_s     = side_r;
        emit_s     = 1'b0;
        err_s      = 1'b0;
        if (bus.in_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (type_legal(bus.in_data)) begin
                        type_s  = (bus.in_data == TYPE_DEL) ? TICK_DEL : TICK_ADD;
                        qty_s   = 32'h0;
                        price_s = 24'h0;
                        if (bus.in_last) begin
                            err_s   = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_SIDE;
                        end
                    end else begin
                        err_s   = 1'b1;
                        state_s = bus.in_last ? ST_IDLE : ST_DISCARD;
                    end
                end
                ST_SIDE: begin
                    if (side_legal(bus.in_data)) begin
                        side_s     = (bus.in_data == SIDE_BID_CH) ? SIDE_BID : SIDE_ASK;
                        byte_idx_s = 4'd2;
                        if (bus.in_last) begin
                            err_s   = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_BODY;
                        end
                    end else begin
                        err_s   = 1'b1;
                        state_s = bus.in_last ? ST_IDLE : ST_DISCARD;
                    end
                end
                ST_BODY: begin
                    if (byte_idx_r == 4'(MSG_LEN - 1)) begin
                        if (!bus.in_last) begin
                            err_s   = 1'b1;
                            state_s = ST_DISCARD;
                        end else if ((price_full_s == 32'h0) ||
                                     ((qty_r == 32'h0) && (type_r == TICK_ADD))) begin
                            err_s   = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            emit_s  = 1'b1;
                            state_s = ST_IDLE;
                        end
                    end else begin
                        if (byte_idx_r < 4'd6) begin
                            qty_s = {qty_r[23:0], bus.in_data};
                        end else begin
                            price_s = {price_r[15:0], bus.in_data};
                        end
                        byte_idx_s = byte_idx_r + 4'd1;
                        if (bus.in_last) begin
                            err_s   = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_BODY;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (bus.in_last) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state and frame datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            byte_idx_r <= 4'd0;
            qty_r      <= 32'h0;
            price_r    <= 24'h0;
            type_r     <= 1'b0;
            side_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            byte_idx_r <= byte_idx_s;
            qty_r      <= qty_s;
            price_r    <= price_s;
            type_r     <= type_s;
            side_r     <= side_s;
        end
    end

    // Output stage: strobe for one cycle, fields held until the next emit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_valid_r <= 1'b0;
            tick_type_r  <= 1'b0;
            tick_side_r  <= 1'b0;
            tick_qty_r   <= '0;
            tick_price_r <= '0;
        end else begin
            tick_valid_r <= emit_s;
            if (emit_s) begin
                tick_type_r  <= type_r;
                tick_side_r  <= side_r;
                tick_qty_r   <= QTY_W'(qty_r);
                tick_price_r <= PX_W'(price_full_s);
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_msg_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (emit_s),
        .count (msg_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_s),
        .count (err_cnt)
    );

    assign bus.in_ready   = rst_n;
    assign bus.tick_valid = tick_valid_r;
    assign bus.tick_type  = tick_type_r;
    assign bus.tick_side  = tick_side_r;
    assign bus.tick_qty   = tick_qty_r;
    assign bus.tick_price = tick_price_r;

endmodule

// File: tb/tb_tick_decoder.sv
// Self-checking bench: directed frames plus randomized frames/gaps against a
// frame-level reference model; a 3-bit-counter instance exercises saturation.
module tb_tick_decoder;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] msg_cnt, err_cnt;
    logic [2:0]  msg3, err3;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tick_cycles[$];

    // reference model state
    logic [7:0]  m_cur[$];
    bit          m_bad = 1'b0;
    int          m_msg = 0, m_err = 0;
    logic        m_tv = 1'b0, m_type = 1'b0, m_side = 1'b0;
    logic [31:0] m_qty = 32'h0, m_price = 32'h0;

    tick_decoder_if bus ();
    tick_decoder_if sat_if ();

    assign sat_if.in_valid = bus.in_valid;
    assign sat_if.in_data  = bus.in_data;
    assign sat_if.in_last  = bus.in_last;

    tick_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .msg_cnt(msg_cnt), .err_cnt(err_cnt)
    );

    tick_decoder #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sat_if.slave), .msg_cnt(msg3), .err_cnt(err3)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Frame-level rules applied to one byte sampled at a clock edge.
    task automatic model_edge(input logic v, input logic [7:0] d, input logic l);
        int n;
        logic [31:0] q, p;
        bit is_add;
        m_tv = 1'b0;
        if (!rst_n) begin
            m_cur.delete(); m_bad = 1'b0; m_msg = 0; m_err = 0;
            m_type = 1'b0; m_side = 1'b0; m_qty = 32'h0; m_price = 32'h0;
            return;
        end
        if (!v) return;
        if (m_bad) begin
            if (l) m_bad = 1'b0;
            return;
        end
        m_cur.push_back(d);
        n = m_cur.size();
        if ((n == 1 && !(d == 8'h41 || d == 8'h58)) || (n == 2 && !(d == 8'h42 || d == 8'h53))) begin
            m_err++; m_cur.delete(); m_bad = !l;
            return;
        end
        if (n < 10) begin
            if (l) begin m_err++; m_cur.delete(); end
            return;
        end
        q = {m_cur[2], m_cur[3], m_cur[4], m_cur[5]};
        p = {m_cur[6], m_cur[7], m_cur[8], m_cur[9]};
        is_add = (m_cur[0] == 8'h41);
        if (!l) begin
            m_err++; m_bad = 1'b1;
        end else if (p == 32'd0 || (q == 32'd0 && is_add)) begin
            m_err++;
        end else begin
            m_tv = 1'b1; m_msg++;
            m_type = is_add ? 1'b0 : 1'b1;
            m_side = (m_cur[1] == 8'h42);
            m_qty = q; m_price = p;
        end
        m_cur.delete();
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l);
        bus.in_valid = v; bus.in_data = d; bus.in_last = l;
        @(posedge clk); #1;
        cyc++;
        model_edge(v, d, l);
        if (bus.tick_valid) tick_cycles.push_back(cyc);
        check_eq("in_ready",   bus.in_ready,   rst_n);
        check_eq("tick_valid", bus.tick_valid, m_tv);
        check_eq("tick_type",  bus.tick_type,  m_type);
        check_eq("tick_side",  bus.tick_side,  m_side);
        check_eq("tick_qty",   bus.tick_qty,   m_qty);
        check_eq("tick_price", bus.tick_price, m_price);
        check_eq("msg_cnt",    msg_cnt, sat(m_msg, 65535));
        check_eq("err_cnt",    err_cnt, sat(m_err, 65535));
        check_eq("msg_cnt_w3", msg3,    sat(m_msg, 7));
        check_eq("err_cnt_w3", err3,    sat(m_err, 7));
    endtask

    task automatic send(input bq_t f, input int gap_pct);
        for (int i = 0; i < f.size(); i++) begin
            while (int'($urandom_range(99)) < gap_pct)
                step(1'b0, 8'($urandom), 1'($urandom));
            step(1'b1, f[i], (i == f.size() - 1));
        end
    endtask

    task automatic mk(input logic [7:0] t, input logic [7:0] s, input logic [31:0] q,
                      input logic [31:0] p, output bq_t f);
        f = {};
        f.push_back(t);
        f.push_back(s);
        for (int i = 3; i >= 0; i--) f.push_back(q[8*i +: 8]);
        for (int i = 3; i >= 0; i--) f.push_back(p[8*i +: 8]);
    endtask

    task automatic mk_random(output bq_t f);
        int kind;
        logic [7:0] t, s;
        logic [31:0] q, p;
        kind = $urandom_range(8);
        t = $urandom_range(1) ? 8'h41 : 8'h58;
        s = $urandom_range(1) ? 8'h42 : 8'h53;
        q = $urandom_range(1) ? 32'($urandom_range(1, 1000)) : ($urandom | 32'h1);
        p = $urandom_range(1) ? 32'($urandom_range(1, 99999)) : ($urandom | 32'h100);
        case (kind)
            2: t = 8'($urandom_range(8'h00, 8'h40));
            3: s = 8'h00;
            6: p = 32'h0;
            7: begin t = 8'h41; q = 32'h0; end
            8: begin t = 8'h58; q = 32'h0; end
            default: ;
        endcase
        mk(t, s, q, p, f);
        if (kind == 4) begin
            int n = $urandom_range(1, 9);
            while (f.size() > n) void'(f.pop_back());
        end
        if (kind == 5) begin
            int x = $urandom_range(1, 3);
            for (int i = 0; i < x; i++) f.push_back(8'($urandom));
        end
    endtask

    initial begin
        bq_t f, g;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
        rst_n = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h41, 1'b0);
        check_eq("reset_msg", msg_cnt, 16'd0);
        check_eq("reset_err", err_cnt, 16'd0);
        rst_n = 1'b1;

        // 1: add bid qty 20 @ 10005
        mk(8'h41, 8'h42, 32'd20, 32'd10005, f);
        send(f, 0);
        check_eq("t1_valid", bus.tick_valid, 1'b1);
        check_eq("t1_qty",   bus.tick_qty,   32'd20);
        check_eq("t1_price", bus.tick_price, 32'd10005);
        check_eq("t1_msg",   msg_cnt,        16'd1);

        // 2: delete ask then add ask back-to-back
        tick_cycles.delete();
        mk(8'h58, 8'h53, 32'd7, 32'd9999, f);
        mk(8'h41, 8'h53, 32'd5, 32'd10010, g);
        send(f, 0);
        send(g, 0);
        check_eq("t2_ticks", tick_cycles.size(), 2);
        if (tick_cycles.size() == 2)
            check_eq("t2_spacing", tick_cycles[1] - tick_cycles[0], 10);
        check_eq("t2_price", bus.tick_price, 32'd10010);
        step(1'b0, 8'h00, 1'b0);

        // 3: illegal type in a 10-byte frame, then a good frame
        mk(8'h5A, 8'h42, 32'd1, 32'd1, f);
        send(f, 0);
        check_eq("t3_err", err_cnt, 16'd1);
        mk(8'h58, 8'h42, 32'd0, 32'd123, f);
        send(f, 0);
        check_eq("t3_valid", bus.tick_valid, 1'b1);

        // 4: short frame (last on b5), then add with qty 0
        mk(8'h41, 8'h42, 32'd3, 32'd4, f);
        while (f.size() > 6) void'(f.pop_back());
        send(f, 0);
        check_eq("t4_short_err", err_cnt, 16'd2);
        mk(8'h41, 8'h42, 32'd0, 32'd500, f);
        send(f, 0);
        check_eq("t4_qty0_err", err_cnt, 16'd3);

        // 5: reset after b4, then a full frame
        mk(8'h41, 8'h53, 32'h01020304, 32'h0A0B0C0D, f);
        for (int i = 0; i < 5; i++) step(1'b1, f[i], 1'b0);
        rst_n = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        check_eq("t5_rst_qty", bus.tick_qty, 32'd0);
        check_eq("t5_rst_msg", msg_cnt, 16'd0);
        rst_n = 1'b1;
        send(f, 0);
        check_eq("t5_qty", bus.tick_qty, 32'h01020304);
        check_eq("t5_err", err_cnt, 16'd0);

        // 6: random frames with gaps; 3-bit instance saturates
        for (int k = 0; k < 300; k++) begin
            mk_random(f);
            send(f, 30);
        end
        check_eq("t6_sat_err", err3, 3'h7);
        check_eq("t6_sat_msg", msg3, 3'h7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
